// File: rtl/pipe_hazard_pkg.sv
// Shared types for the EXE/MEM/WB destination-tag tracker.
package pipe_hazard_pkg;

  localparam int unsigned REG_W = 4;

  typedef struct packed {
    logic             wb_en;
    logic [REG_W-1:0] dest;
    logic             mem_r_en;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '0;

  // A tag only ever matches when it will actually write the register file.
  function automatic logic tag_matches(input stage_tag_t       tag,
                                       input logic [REG_W-1:0] src1,
                                       input logic [REG_W-1:0] src2,
                                       input logic             two_src);
    tag_matches = tag.wb_en && ((tag.dest == src1) || (two_src && (tag.dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage tag register: async reset, hold on freeze, load otherwise.
module hazard_stage_reg
  import pipe_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  stage_tag_t tag_d,
  output stage_tag_t tag_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= BUBBLE_TAG;
    end else if (!freeze) begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Destination-tag tracker and stall generator for the 5-stage pipeline.
// PIPE_FORWARDING_EN defined: only load-use stalls; undefined: stall on any EXE/MEM RAW.
module pipe_hazard_tracker #(
  parameter int unsigned REG_W = pipe_hazard_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_mem_r_en,
  output logic             hazard,
  output logic             exe_wb_en,
  output logic             mem_wb_en,
  output logic             wb_wb_en,
  output logic [REG_W-1:0] exe_dest,
  output logic [REG_W-1:0] mem_dest,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] hazard_cnt
);

  import pipe_hazard_pkg::*;

  stage_tag_t id_tag;
  stage_tag_t exe_d;
  stage_tag_t exe_q;
  stage_tag_t mem_q;
  stage_tag_t wb_q;

  logic             exe_hit;
  logic             mem_hit;
  logic             raw_hazard;
  logic             id_accept;
  logic [CNT_W-1:0] hazard_cnt_d;
  logic [CNT_W-1:0] hazard_cnt_q;

  // The WB load flag has no consumer; the register file is written ahead of the ID read.
  logic unused_wb_mem_r_en;
  assign unused_wb_mem_r_en = wb_q.mem_r_en;

  assign id_tag = '{wb_en: id_wb_en, dest: id_dest, mem_r_en: id_mem_r_en};

  always_comb begin
    exe_hit = tag_matches(exe_q, id_src1, id_src2, id_two_src);
    mem_hit = tag_matches(mem_q, id_src1, id_src2, id_two_src);
`ifdef PIPE_FORWARDING_EN
    raw_hazard = exe_hit && exe_q.mem_r_en;
`else
    raw_hazard = exe_hit || mem_hit;
`endif
    // A flushed instruction is dead, so it must neither stall nor enter EXE.
    hazard    = id_valid && !flush && raw_hazard;
    id_accept = id_valid && !flush && !hazard;
    exe_d     = id_accept ? id_tag : BUBBLE_TAG;
  end

`ifdef PIPE_FORWARDING_EN
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
`endif

  hazard_stage_reg u_exe_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .tag_d  (exe_d),
    .tag_q  (exe_q)
  );

  hazard_stage_reg u_mem_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .tag_d  (exe_q),
    .tag_q  (mem_q)
  );

  hazard_stage_reg u_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .tag_d  (mem_q),
    .tag_q  (wb_q)
  );

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (hazard && !freeze && (hazard_cnt_q != {CNT_W{1'b1}})) begin
      hazard_cnt_d = hazard_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt_q <= '0;
    end else begin
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign exe_wb_en  = exe_q.wb_en;
  assign mem_wb_en  = mem_q.wb_en;
  assign wb_wb_en   = wb_q.wb_en;
  assign exe_dest   = exe_q.dest;
  assign mem_dest   = mem_q.dest;
  assign wb_dest    = wb_q.dest;
  assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed bench for pipe_hazard_tracker; expectations follow the PIPE_FORWARDING_EN build.
module tb_pipe_hazard_tracker;

  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 8;

`ifdef PIPE_FORWARDING_EN
  localparam int unsigned CNT_AFTER_LU  = 1;
  localparam int unsigned CNT_AFTER_ALU = 1;
  localparam int unsigned STALLS_90     = 45;
  localparam int unsigned STALLS_600    = 300;
`else
  localparam int unsigned CNT_AFTER_LU  = 2;
  localparam int unsigned CNT_AFTER_ALU = 4;
  localparam int unsigned STALLS_90     = 60;
  localparam int unsigned STALLS_600    = 400;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             freeze;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r_en;
  logic             hazard;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             wb_wb_en;
  logic [REG_W-1:0] exe_dest;
  logic [REG_W-1:0] mem_dest;
  logic [REG_W-1:0] wb_dest;
  logic [CNT_W-1:0] hazard_cnt;

  logic             sat_hazard;
  logic             sat_exe_wb_en;
  logic             sat_mem_wb_en;
  logic             sat_wb_wb_en;
  logic [REG_W-1:0] sat_exe_dest;
  logic [REG_W-1:0] sat_mem_dest;
  logic [REG_W-1:0] sat_wb_dest;
  logic [SAT_W-1:0] sat_hazard_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_mem_r_en (id_mem_r_en),
    .hazard      (hazard),
    .exe_wb_en   (exe_wb_en),
    .mem_wb_en   (mem_wb_en),
    .wb_wb_en    (wb_wb_en),
    .exe_dest    (exe_dest),
    .mem_dest    (mem_dest),
    .wb_dest     (wb_dest),
    .hazard_cnt  (hazard_cnt)
  );

  // Narrow-counter copy on the same stimulus, so saturation is reachable quickly.
  pipe_hazard_tracker #(.REG_W(REG_W), .CNT_W(SAT_W)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_mem_r_en (id_mem_r_en),
    .hazard      (sat_hazard),
    .exe_wb_en   (sat_exe_wb_en),
    .mem_wb_en   (sat_mem_wb_en),
    .wb_wb_en    (sat_wb_wb_en),
    .exe_dest    (sat_exe_dest),
    .mem_dest    (sat_mem_dest),
    .wb_dest     (sat_wb_dest),
    .hazard_cnt  (sat_hazard_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                       input logic two, input logic wb, input logic [REG_W-1:0] d,
                       input logic mr);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_wb_en    = wb;
    id_dest     = d;
    id_mem_r_en = mr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    rst_n  = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    idle();

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom));
      freeze = 1'($urandom);
      flush  = 1'($urandom);
      cyc();
    end
    check_eq("rst_hazard", 32'(hazard), 32'd0);
    check_eq("rst_exe_wb_en", 32'(exe_wb_en), 32'd0);
    check_eq("rst_mem_wb_en", 32'(mem_wb_en), 32'd0);
    check_eq("rst_wb_wb_en", 32'(wb_wb_en), 32'd0);
    check_eq("rst_exe_dest", 32'(exe_dest), 32'd0);
    check_eq("rst_mem_dest", 32'(mem_dest), 32'd0);
    check_eq("rst_wb_dest", 32'(wb_dest), 32'd0);
    check_eq("rst_cnt", 32'(hazard_cnt), 32'd0);
    freeze = 1'b0;
    flush  = 1'b0;
    idle();
    rst_n = 1'b1;
    cyc();
    cyc();
    check_eq("post_rst_cnt", 32'(hazard_cnt), 32'd0);

    // Load-use: LDR R1 then ADD R2 <- R1
    drive(1'b1, 4'd2, 4'd3, 1'b0, 1'b1, 4'd1, 1'b1);
    #1;
    check_eq("lu_first_hazard", 32'(hazard), 32'd0);
    cyc();
    check_eq("lu_exe_dest", 32'(exe_dest), 32'd1);
    check_eq("lu_exe_wb_en", 32'(exe_wb_en), 32'd1);
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    #1;
    check_eq("lu_stall", 32'(hazard), 32'd1);
    cyc();
    check_eq("lu_bubble", 32'(exe_wb_en), 32'd0);
    check_eq("lu_mem_dest", 32'(mem_dest), 32'd1);
    check_eq("lu_mem_wb_en", 32'(mem_wb_en), 32'd1);
    check_eq("lu_cnt1", 32'(hazard_cnt), 32'd1);
`ifdef PIPE_FORWARDING_EN
    check_eq("lu_release", 32'(hazard), 32'd0);
`else
    check_eq("lu_mem_stall", 32'(hazard), 32'd1);
    cyc();
    check_eq("lu_release", 32'(hazard), 32'd0);
    check_eq("lu_wb_dest", 32'(wb_dest), 32'd1);
`endif
    cyc();
    check_eq("lu_add_exe", 32'(exe_dest), 32'd2);
    check_eq("lu_cnt", 32'(hazard_cnt), CNT_AFTER_LU);
    drain();

    // ALU dependency through src2: ADD R1 then SUB R4 <- R5, R1
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
    cyc();
    drive(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 4'd4, 1'b0);
    #1;
`ifdef PIPE_FORWARDING_EN
    check_eq("alu_no_stall", 32'(hazard), 32'd0);
    cyc();
`else
    check_eq("alu_stall1", 32'(hazard), 32'd1);
    cyc();
    check_eq("alu_stall2", 32'(hazard), 32'd1);
    check_eq("alu_bubble", 32'(exe_wb_en), 32'd0);
    cyc();
    check_eq("alu_release", 32'(hazard), 32'd0);
    cyc();
`endif
    check_eq("alu_sub_exe", 32'(exe_dest), 32'd4);
    check_eq("alu_cnt", 32'(hazard_cnt), CNT_AFTER_ALU);
    drain();

    // src2 ignored unless id_two_src, and no stall without id_valid
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
    cyc();
    drive(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 4'd5, 1'b0);
    #1;
    check_eq("src2_unused", 32'(hazard), 32'd0);
    id_two_src = 1'b1;
    #1;
    check_eq("src2_used", 32'(hazard), 32'd1);
    id_valid = 1'b0;
    #1;
    check_eq("invalid_id", 32'(hazard), 32'd0);
    idle();

    // A tag with wb_en=0 never matches
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1);
    cyc();
    drive(1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 4'd7, 1'b0);
    #1;
    check_eq("no_wb_en_match", 32'(hazard), 32'd0);
    drain();

    // Freeze during a load-use stall, then flush
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
    cyc();
    drive(1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0);
    #1;
    check_eq("frz_stall", 32'(hazard), 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("frz_exe_dest", 32'(exe_dest), 32'd7);
      check_eq("frz_exe_wb_en", 32'(exe_wb_en), 32'd1);
      check_eq("frz_mem_wb_en", 32'(mem_wb_en), 32'd0);
      check_eq("frz_hazard", 32'(hazard), 32'd1);
      check_eq("frz_cnt", 32'(hazard_cnt), CNT_AFTER_ALU);
    end
    freeze = 1'b0;
    flush  = 1'b1;
    #1;
    check_eq("flush_hazard", 32'(hazard), 32'd0);
    cyc();
    check_eq("flush_bubble", 32'(exe_wb_en), 32'd0);
    check_eq("flush_mem_dest", 32'(mem_dest), 32'd7);
    check_eq("flush_cnt", 32'(hazard_cnt), CNT_AFTER_ALU);
    flush = 1'b0;
    drain();

    // Reset mid-operation clears in-flight tags at once
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    cyc();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0);
    cyc();
    drive(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 4'd11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_exe_wb_en", 32'(exe_wb_en), 32'd0);
    check_eq("mid_rst_mem_wb_en", 32'(mem_wb_en), 32'd0);
    check_eq("mid_rst_exe_dest", 32'(exe_dest), 32'd0);
    check_eq("mid_rst_mem_dest", 32'(mem_dest), 32'd0);
    check_eq("mid_rst_cnt", 32'(hazard_cnt), 32'd0);
    check_eq("mid_rst_hazard", 32'(hazard), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_hazard", 32'(hazard), 32'd0);
    cyc();
    check_eq("rst_release_exe", 32'(exe_dest), 32'd11);
    check_eq("rst_release_cnt", 32'(hazard_cnt), 32'd0);

    // Back-to-back self-dependent loads: steady stall stream
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (90) cyc();
    check_eq("stream_cnt_90", 32'(hazard_cnt), STALLS_90);
    check_eq("sat_cnt_90", 32'(sat_hazard_cnt), STALLS_90);
    repeat (510) cyc();
    check_eq("stream_cnt_600", 32'(hazard_cnt), STALLS_600);
    check_eq("sat_cnt_600", 32'(sat_hazard_cnt), 32'hFF);
    repeat (20) cyc();
    check_eq("sat_hold", 32'(sat_hazard_cnt), 32'hFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_tracker.md
# pipe_hazard_tracker

Tracks the destination tags of instructions in flight through EXE, MEM and WB of the 5-stage ARM pipeline. Supplies the stage write-enable/destination pairs the forwarding logic consumes and raises `hazard` when the instruction in ID must stall. Sits beside the ID/EXE boundary. Receives decode fields from ID and drives the stall/bubble control back into IF/ID.

## Interface
- Parameters
  - `REG_W`, 4, register index width
  - `CNT_W`, 16, stall-counter width
- Ports (one clock; reset is asynchronous and active-low)
  - `clk` in 1: pipeline clock
  - `rst_n` in 1: asynchronous active-low reset
  - `freeze` in 1: memory wait; hold all state
  - `flush` in 1: taken branch; ID instruction must not enter EXE
  - `id_valid` in 1: ID holds a real instruction
  - `id_src1`, `id_src2` in REG_W: ID source registers
  - `id_two_src` in 1: `id_src2` is actually read
  - `id_wb_en` in 1: ID instruction writes the register file
  - `id_dest` in REG_W: ID destination register
  - `id_mem_r_en` in 1: ID instruction is a load
  - `hazard` out 1: stall IF/ID, insert bubble into EXE
  - `exe_wb_en`, `mem_wb_en`, `wb_wb_en` out 1: stage write-enables
  - `exe_dest`, `mem_dest`, `wb_dest` out REG_W: stage destinations
  - `hazard_cnt` out CNT_W: saturating count of stall cycles

## Operation
- There are three stage tags, EXE, MEM and WB. Each tag is {wb_en, dest, mem_r_en}. All stage outputs come straight from these registers.
- Each clock edge with `freeze`=0:
  - WB←MEM
  - MEM←EXE
  - EXE←ID fields if `id_valid && !hazard && !flush`, otherwise bubble (all zero)
- Each clock edge with `freeze`=1: every tag and `hazard_cnt` holds.
- `hazard` is combinational from the EXE/MEM tags and the ID inputs.
- src2 takes part in matching only when `id_two_src`=1.
- `hazard` is forced to 0 when `id_valid`=0 or `flush`=1. Flush takes priority; the killed instruction does not stall.
- A tag with `wb_en`=0 never matches, whatever its `dest` value.
- `hazard_cnt` increments on each edge where `hazard && !freeze`. It saturates at all-ones and never wraps.
- The WB tag never causes a stall. The register file writes before the ID read in the same cycle.

## Timing
- Reset (asynchronous, `rst_n`=0): all tags zero, so all `*_wb_en`=0, all `*_dest`=0, `hazard_cnt`=0. `hazard` is 0 while `id_valid` is low.
- A tag moves one stage per unfrozen cycle. An instruction accepted at edge N appears on `exe_*` after N, on `mem_*` after N+1 and on `wb_*` after N+2.
- A load-use stall lasts exactly 1 unfrozen cycle. The load then sits in MEM, so forwarding covers the dependency.
- `freeze` arriving mid-stall stretches the stall. `hazard` stays asserted and the count does not advance.
- Reset asserted mid-operation clears all in-flight tags immediately. No stall persists after release.

## Configuration
- Macro: `PIPE_FORWARDING_EN`.
- Defined (forwarding on): `hazard` = EXE.wb_en && EXE.mem_r_en && (EXE.dest matches a used source). Only load-use stalls.
- Undefined (forwarding off): `hazard` = a used source matches EXE.dest with EXE.wb_en, or matches MEM.dest with MEM.wb_en.
- The stage outputs are driven identically in both builds.

## Structure
- Package `pipe_hazard_pkg` holds:
  - `REG_W` default
  - `stage_tag_t` packed struct {wb_en, dest, mem_r_en}
  - `BUBBLE_TAG` constant
- Sub-module `hazard_stage_reg`: one `stage_tag_t` register with asynchronous reset, hold (`freeze`) and load. It is instantiated three times.
- The top level contains the match/stall logic and the counter.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs 0; after release `hazard_cnt`=0.
- Load-use, macro defined: issue LDR R1 (wb_en=1, dest=1, mem_r_en=1), then ADD src1=1.
  - `hazard`=1 for one cycle and EXE gets a bubble.
  - Next cycle `hazard`=0 and `mem_dest`=1, `mem_wb_en`=1.
  - `hazard_cnt`=1.
- ALU dependency: ADD dest=1, then SUB src2=1 with `id_two_src`=1.
  - Macro defined: `hazard` stays 0.
  - Macro undefined: `hazard`=1 for 2 cycles, `hazard_cnt`=2.
- Unused src2: EXE holds a load with dest=3 while ID has src2=3 and `id_two_src`=0. `hazard`=0.
- Freeze and flush:
  - Assert `freeze` for 3 cycles during a load-use stall: tags unchanged, `hazard` held at 1, `hazard_cnt` unchanged.
  - Then `flush`=1 with a valid ID instruction: `hazard`=0, EXE becomes the bubble (`exe_wb_en`=0).
- Saturation: force 70000 stall cycles with CNT_W=16. `hazard_cnt` stops at 0xFFFF.
